debounce_n: RTL and testbench

//  Synchronises and debounces WIDTH asynchronous switch/button inputs into clk.

---
 rtl/debounce_n_pkg.sv | 11 +
 rtl/debounce_n_if.sv | 20 ++
 rtl/debounce_bit.sv | 56 +++++
 rtl/debounce_n.sv | 41 ++++
 tb/tb_debounce_n.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_n_pkg.sv
// rtl/debounce_n_pkg.sv - shared constants and sizing helper for the debounce_n block
package debounce_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    // Counter must hold values 0..stable_cycles-1 without wrapping.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_n_if.sv
// rtl/debounce_n_if.sv - raw input / debounced output bundle for debounce_n
// busy is present only when DEBOUNCE_N_BUSY_EN is defined.
interface debounce_n_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;

`ifdef DEBOUNCE_N_BUSY_EN
    logic [WIDTH-1:0] busy;

    modport master (output a, input q, input busy);
    modport slave  (input a, output q, output busy);
`else
    modport master (output a, input q);
    modport slave  (input a, output q);
`endif

endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one bit of debounce_n: synchroniser chain, stability counter, q flop
// Optional busy output is present only when DEBOUNCE_N_BUSY_EN is defined.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic q
`ifdef DEBOUNCE_N_BUSY_EN
    ,
    output logic busy
`endif
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], a};
        end
    end

    // Any agreement between s and q discards a partial count; q moves only on a full run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            q   <= RST_VAL;
        end else if (s == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef DEBOUNCE_N_BUSY_EN
    assign busy = (s != q);
`endif

endmodule

// File: rtl/debounce_n.sv
// rtl/debounce_n.sv - WIDTH-bit synchronising switch debouncer, one debounce_bit per input
// Define DEBOUNCE_N_BUSY_EN to add the per-bit busy output.
module debounce_n
    import debounce_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
    input  logic       clk,
    input  logic       rst,
    debounce_n_if.slave bus
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
        $error("debounce_n: SYNC_STAGES must be at least MIN_SYNC_STAGES");
    end

    if (STABLE_CYCLES < 1) begin : g_chk_stable
        $error("debounce_n: STABLE_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RST_VAL       (RST_VAL[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .a    (bus.a[i]),
            .q    (bus.q[i])
`ifdef DEBOUNCE_N_BUSY_EN
            ,
            .busy (bus.busy[i])
`endif
        );
    end

endmodule

// File: tb/tb_debounce_n.sv
// tb/tb_debounce_n.sv - randomized and directed check of debounce_n against a history-window model
// Busy checks are compiled in when DEBOUNCE_N_BUSY_EN is defined.
module tb_debounce_n;

    localparam int         W    = 4;
    localparam int         SS   = 2;
    localparam int         SC   = 4;
    localparam logic [3:0] RV   = 4'h0;
    localparam logic [3:0] RV2  = 4'hA;
    localparam int         MAXE = 8192;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   check_en;

    debounce_n_if #(.WIDTH(W)) bus ();
    debounce_n_if #(.WIDTH(W)) bus2 ();

    debounce_n #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    debounce_n #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RST_VAL(RV2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a_hist[n] is the raw input captured at posedge n after reset release.
    // The synced bit compared at edge k is the raw input from edge k-SS.
    // q flips at edge k when s disagreed with q on each of the last SC edges since q last moved.
    logic [W-1:0] a_hist [0:MAXE-1];
    logic [W-1:0] qm;
    int           n;
    int           last_chg [W];

    function automatic logic s_at(input int k, input int i);
        if (k - SS < 1) return RV[i];
        return a_hist[k - SS][i];
    endfunction

    function automatic logic [W-1:0] busy_model();
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = (s_at(n + 1, i) != qm[i]);
        return b;
    endfunction

    initial begin
        n  = 0;
        qm = RV;
        for (int i = 0; i < W; i++) last_chg[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n  = 0;
                qm = RV;
                for (int i = 0; i < W; i++) last_chg[i] = 0;
            end else begin
                logic [W-1:0] qn;
                n = n + 1;
                if (n >= MAXE) $fatal(1, "FAIL model_hist: history overflow at %0d", n);
                a_hist[n] = bus.a;
                qn = qm;
                for (int i = 0; i < W; i++) begin
                    if (n - last_chg[i] >= SC) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        for (int j = 0; j < SC; j++)
                            if (s_at(n - j, i) == qm[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            qn[i]       = ~qm[i];
                            last_chg[i] = n;
                        end
                    end
                end
                qm = qn;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("q_model", 32'(bus.q), 32'(qm));
            check("q_rstval_a", 32'(bus2.q), 32'(RV2));
`ifdef DEBOUNCE_N_BUSY_EN
            check("busy_model", 32'(bus.busy), 32'(busy_model()));
            check("busy_rstval_a", 32'(bus2.busy), 32'h0);
`endif
        end
    end

    initial begin
        int busy_cnt;
        int den;
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        rst         = 1'b0;
        bus.a       = 4'hF;
        bus2.a      = RV2;
        busy_cnt    = 0;

        // Async reset with no clock edge: q must take RST_VAL at once.
        #3 rst = 1'b1;
        #1 check("rst_async_q", 32'(bus.q), 32'h0);
        check("rst_async_q_a", 32'(bus2.q), 32'hA);
`ifdef DEBOUNCE_N_BUSY_EN
        check("rst_async_busy", 32'(bus.busy), 32'h0);
`endif
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_held_q", 32'(bus.q), 32'h0);
        bus.a = 4'h0;
        rst   = 1'b0;
        repeat (8) @(negedge clk);

        // Clean step on a[0]: q[0] rises at the 6th posedge.
        bus.a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
`ifdef DEBOUNCE_N_BUSY_EN
            if (bus.busy[0]) busy_cnt++;
`endif
            if (k == 5) check("step_q_before", 32'(bus.q), 32'h0);
            if (k == 6) check("step_q_at6", 32'(bus.q), 32'h1);
        end
`ifdef DEBOUNCE_N_BUSY_EN
        check("busy0_cycles", 32'(busy_cnt), 32'd4);
`endif

        // Pulse of 3 synced cycles is rejected.
        bus.a[1] = 1'b1;
        repeat (3) @(negedge clk);
        bus.a[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("short_pulse_q1", 32'(bus.q[1]), 32'h0);
        end
        // Pulse of 4 synced cycles is accepted at the edge completing the 4th.
        bus.a[1] = 1'b1;
        repeat (4) @(negedge clk);
        bus.a[1] = 1'b0;
        check("pulse4_q1_pre", 32'(bus.q[1]), 32'h0);
        @(negedge clk);
        check("pulse4_q1_k5", 32'(bus.q[1]), 32'h0);
        @(negedge clk);
        check("pulse4_q1_k6", 32'(bus.q[1]), 32'h1);
        repeat (12) @(negedge clk);

        // Bouncing a[2] then a final rising edge: one transition only.
        for (int t = 0; t < 10; t++) begin
            bus.a[2] = ~bus.a[2];
            repeat (2) begin
                @(negedge clk);
                check("bounce_q2", 32'(bus.q[2]), 32'h0);
            end
        end
        bus.a[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) check("bounce_final_k5", 32'(bus.q[2]), 32'h0);
            if (k == 6) check("bounce_final_k6", 32'(bus.q[2]), 32'h1);
        end

        // Reset while cnt[3] == 3; a full interval is needed after release.
        bus.a[3] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("midcount_rst_q3", 32'(bus.q[3]), 32'h0);
        @(negedge clk);
        check("midcount_rst_q", 32'(bus.q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) check("post_rst_q3_k5", 32'(bus.q[3]), 32'h0);
            if (k == 6) check("post_rst_q3_k6", 32'(bus.q[3]), 32'h1);
        end

        // Randomized bounce with varying activity and occasional async resets.
        for (int seg = 0; seg < 20; seg++) begin
            case ($urandom_range(0, 4))
                0: den = 2;
                1: den = 3;
                2: den = 6;
                3: den = 10;
                default: den = 20;
            endcase
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < W; i++)
                    if ($urandom_range(0, den - 1) == 0) bus.a[i] = ~bus.a[i];
                @(negedge clk);
                if ($urandom_range(0, 199) == 0) begin
                    #($urandom_range(1, 4)) rst = 1'b1;
                    #1 check("rand_rst_q", 32'(bus.q), 32'(RV));
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        end

        repeat (10) @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
